// File: rtl/tile_addr_gen.sv
// Row/col/chan nested-loop address generator with border padding. Addresses come
// from running accumulators (no multipliers) and leave on a valid/ready beat stream.
module tile_addr_gen #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           IDX_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] NULL_ADDR  = {(ADDR_WIDTH/4){4'h9}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [IDX_WIDTH-1:0]  cfg_rows,
    input  logic [IDX_WIDTH-1:0]  cfg_cols,
    input  logic [IDX_WIDTH-1:0]  cfg_chans,
    input  logic [ADDR_WIDTH-1:0] cfg_row_stride,
    input  logic [ADDR_WIDTH-1:0] cfg_col_stride,
    input  logic [ADDR_WIDTH-1:0] cfg_chan_stride,
    input  logic [IDX_WIDTH-1:0]  cfg_pad,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic [IDX_WIDTH-1:0]  row_o,
    output logic [IDX_WIDTH-1:0]  col_o,
    output logic [IDX_WIDTH-1:0]  chan_o,
    output logic                  pad_o,
    output logic                  last_o,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] IDX_ZERO = '0;
    localparam logic [IDX_WIDTH-1:0] IDX_ONE  = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

    // Index i is interior when P <= i < n-P; the extra bit keeps i+P from overflowing,
    // and 2P >= n naturally leaves no interior index.
    function automatic logic in_range(input logic [IDX_WIDTH-1:0] i,
                                      input logic [IDX_WIDTH-1:0] n,
                                      input logic [IDX_WIDTH-1:0] p);
        logic [IDX_WIDTH:0] ie, ne, pe;
        ie = {1'b0, i};
        ne = {1'b0, n};
        pe = {1'b0, p};
        return (ie >= pe) && ((ie + pe) < ne);
    endfunction

    state_t                state_q;
    logic [IDX_WIDTH-1:0]  rows_q, cols_q, chans_q, padw_q;
    logic [ADDR_WIDTH-1:0] rs_q, cs_q, chs_q;
    logic [IDX_WIDTH-1:0]  row_q, col_q, chan_q;
    logic [ADDR_WIDTH-1:0] row_acc_q, col_acc_q, ch_acc_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  valid_q, pad_q, last_q, done_q;

    logic [IDX_WIDTH-1:0]  row_d, col_d, chan_d;
    logic [ADDR_WIDTH-1:0] row_acc_d, col_acc_d, ch_acc_d, addr_d;
    logic                  pad_d, last_d;
    logic [IDX_WIDTH-1:0]  rows_m1, cols_m1, chans_m1;
    logic                  row_int, col_int;
    logic                  first_pad, first_last, zero_dim;
    logic [ADDR_WIDTH-1:0] first_addr;

    assign rows_m1  = rows_q - IDX_ONE;
    assign cols_m1  = cols_q - IDX_ONE;
    assign chans_m1 = chans_q - IDX_ONE;
    assign row_int  = in_range(row_q, rows_q, padw_q);
    assign col_int  = in_range(col_q, cols_q, padw_q);

    assign zero_dim   = (cfg_rows == IDX_ZERO) || (cfg_cols == IDX_ZERO) || (cfg_chans == IDX_ZERO);
    assign first_pad  = !(in_range(IDX_ZERO, cfg_rows, cfg_pad) && in_range(IDX_ZERO, cfg_cols, cfg_pad));
    assign first_last = (cfg_rows == IDX_ONE) && (cfg_cols == IDX_ONE) && (cfg_chans == IDX_ONE);
    assign first_addr = first_pad ? NULL_ADDR : cfg_base;

    // Next beat after the current one; row/col accumulators only step past interior indices.
    always_comb begin
        chan_d    = chan_q + IDX_ONE;
        col_d     = col_q;
        row_d     = row_q;
        ch_acc_d  = ch_acc_q + chs_q;
        col_acc_d = col_acc_q;
        row_acc_d = row_acc_q;
        if (chan_q == chans_m1) begin
            chan_d    = IDX_ZERO;
            col_d     = col_q + IDX_ONE;
            col_acc_d = col_int ? (col_acc_q + cs_q) : col_acc_q;
            if (col_q == cols_m1) begin
                col_d     = IDX_ZERO;
                row_d     = row_q + IDX_ONE;
                row_acc_d = row_int ? (row_acc_q + rs_q) : row_acc_q;
                col_acc_d = row_acc_d;
            end
            ch_acc_d = col_acc_d;
        end
        pad_d  = !(in_range(row_d, rows_q, padw_q) && in_range(col_d, cols_q, padw_q));
        last_d = (row_d == rows_m1) && (col_d == cols_m1) && (chan_d == chans_m1);
        addr_d = pad_d ? NULL_ADDR : ch_acc_d;
    end

    // Handshake: a beat moves when addr_valid && addr_ready at a rising edge. While
    // addr_valid is high and addr_ready low, addr_o/indices/pad_o/last_o hold, and
    // addr_valid only falls after a transfer, on abort, or on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            chans_q   <= '0;
            padw_q    <= '0;
            rs_q      <= '0;
            cs_q      <= '0;
            chs_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            chan_q    <= '0;
            row_acc_q <= '0;
            col_acc_q <= '0;
            ch_acc_q  <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            pad_q     <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        rows_q    <= cfg_rows;
                        cols_q    <= cfg_cols;
                        chans_q   <= cfg_chans;
                        padw_q    <= cfg_pad;
                        rs_q      <= cfg_row_stride;
                        cs_q      <= cfg_col_stride;
                        chs_q     <= cfg_chan_stride;
                        row_q     <= '0;
                        col_q     <= '0;
                        chan_q    <= '0;
                        row_acc_q <= cfg_base;
                        col_acc_q <= cfg_base;
                        ch_acc_q  <= cfg_base;
                        if (zero_dim) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            valid_q <= 1'b1;
                            addr_q  <= first_addr;
                            pad_q   <= first_pad;
                            last_q  <= first_last;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        pad_q   <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (valid_q && addr_ready) begin
                        if (last_q) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            pad_q   <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            row_q     <= row_d;
                            col_q     <= col_d;
                            chan_q    <= chan_d;
                            row_acc_q <= row_acc_d;
                            col_acc_q <= col_acc_d;
                            ch_acc_q  <= ch_acc_d;
                            addr_q    <= addr_d;
                            pad_q     <= pad_d;
                            last_q    <= last_d;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign addr_o      = addr_q;
    assign addr_valid  = valid_q;
    assign row_o       = row_q;
    assign col_o       = col_q;
    assign chan_o      = chan_q;
    assign pad_o       = pad_q;
    assign last_o      = last_q;
    assign done        = done_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: doc/tile_addr_gen.md
Name: tile_addr_gen

Overview:
- Parametrised 3-level nested-loop address generator for tiled accelerator memory traffic: iterates row, column and channel, emitting one address per valid/ready beat.
- Uses the common address/index widths and the invalid-address marker. Adds a padding mode: border positions emit NULL_ADDR instead of a memory address.
- Sits between the layer controller and the DMA/buffer read ports.

Parameters:
- ADDR_WIDTH, 32, address/stride width.
- IDX_WIDTH, 8, dimension/index width.
- NULL_ADDR, {ADDR_WIDTH/4{4'h9}} (32'h9999_9999 at default), marker emitted for padded positions.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse; latches cfg_* when idle.
- abort  in  1  synchronous; returns to IDLE with no done.
- cfg_base  in  ADDR_WIDTH  base address of interior element (0,0,0).
- cfg_rows / cfg_cols / cfg_chans  in  IDX_WIDTH each  loop counts, including padding border for rows/cols.
- cfg_row_stride / cfg_col_stride / cfg_chan_stride  in  ADDR_WIDTH each  byte strides.
- cfg_pad  in  IDX_WIDTH  border width P applied to rows and cols.
- addr_o  out  ADDR_WIDTH  generated address.
- addr_valid  out  1  beat valid.
- addr_ready  in  1  consumer ready.
- row_o / col_o / chan_o  out  IDX_WIDTH each  current indices.
- pad_o  out  1  current beat is padding.
- last_o  out  1  final beat of the pass.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset: state IDLE; all outputs 0; all counters and accumulators 0.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: start latches all cfg_*.
  - Any of rows/cols/chans = 0: go to DONE (no beats).
  - Otherwise go to RUN with indices (0,0,0).
  - start while busy is ignored.
- Latency: start at cycle T gives addr_valid=1 at T+1.
- Throughput: 1 beat/cycle while addr_ready=1.
- Loop order: chan innermost, then col, then row.
- Padding: beat is pad when r<P, r>=rows-P, c<P or c>=cols-P.
  - pad_o=1 and addr_o=NULL_ADDR on a pad beat.
  - If 2P >= rows or 2P >= cols, every beat is a pad beat.
- Interior address: cfg_base + (r-P)*row_stride + (c-P)*col_stride + ch*chan_stride, modulo 2^ADDR_WIDTH (wraps silently).
  - Must be built incrementally from accumulators; no multipliers.
  - Row/col accumulators advance only when leaving an interior index.
- Handshake: a beat transfers when addr_valid & addr_ready.
  - While addr_valid & !addr_ready, addr_o, indices, pad_o and last_o hold stable.
  - addr_valid never drops without a transfer (except abort or reset).
- last_o=1 exactly on the beat (rows-1, cols-1, chans-1).
- Transfer of the last beat: addr_valid drops the next cycle, state goes to DONE.
- DONE: done=1 for one cycle, then IDLE. A new start may be accepted the cycle after DONE.
- abort in RUN or DONE: next cycle IDLE, addr_valid=0, no done pulse.
  - abort and start in the same cycle while idle: abort wins, stay IDLE.
- Asynchronous reset mid-run: outputs 0 immediately; subsequent start behaves as after power-up.
- Counters must wrap correctly at the IDX_WIDTH maximum (e.g. rows=255 at IDX_WIDTH=8). There is no off-by-one overflow of the count compare.
- Size target: 150-300 lines of RTL.

Test Plan:
- No padding: rows=2, cols=2, chans=2, base=0x1000, rs=0x100, cs=0x10, chs=1, P=0, ready=1.
  -> 8 consecutive beats 0x1000, 1001, 1010, 1011, 1100, 1101, 1110, 1111.
  -> last_o on the 8th; done one cycle later; busy low the cycle after that.
- Padding: rows=3, cols=3, chans=1, P=1, base=0x2000.
  -> 9 beats; only (1,1) is 0x2000 with pad_o=0; the other 8 are 0x9999_9999 with pad_o=1.
- Backpressure: first case with addr_ready random ~50%.
  -> same 8-address sequence, no duplicate or skip; outputs stable during stalls.
- Zero dimension: cols=0 -> addr_valid never asserted; done at T+1.
- Wrap: base=0xFFFF_FFF0, chs=0x10, chans=2, rows=cols=1 -> 0xFFFF_FFF0 then 0x0000_0000.
- Abort/reset: abort on beat 3 of the first case -> IDLE, no done; restart yields the full 8 beats.
  - rst asserted mid-run -> all outputs 0 immediately.
  - Repeat the first case with IDX_WIDTH=4 and rows=15 -> 15*2*2 beats.
